mem_load_arb: RTL and testbench

Program-load controller and data-port arbiter for the unified 64-bit instruction/data memory. It sits between the CPU data port, the UART receive byte stream and the memory's single write/data-address port. When a load is triggered it holds the CPU in reset, assembles received bytes into big-endian doublewords and writes them from byte address 0 upward. Otherwise it passes CPU data accesses straight through.

---
 rtl/mem_load_arb.sv | 195 +++++++++++++++++++
 tb/tb_mem_load_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_arb.sv
// mem_load_arb: program-load controller and data-port arbiter for the unified
// 64-bit instruction/data memory. While idle, CPU data accesses pass straight
// through to the memory port. A load holds the CPU in reset, takes a count
// byte C, then assembles C big-endian doublewords from the UART byte stream
// and writes them from byte address 0 upward.
// Optional feature macro: LOADER_CHKSUM_EN -- adds a trailing checksum byte
// (CHK state). The byte must make the mod-256 sum of the payload zero.
module mem_load_arb #(
   parameter int N = 64,
   parameter int L = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld_start,
   input  logic         ld_valid,
   input  logic [7:0]   ld_byte,
   output logic         ld_busy,
   output logic         ld_done,
   output logic         ld_err,
   output logic [7:0]   ld_count,
   output logic         cpu_reset,
   input  logic [1:0]   cpu_memwrite,
   input  logic         cpu_dword,
   input  logic [N-1:0] cpu_dataadr,
   input  logic [N-1:0] cpu_writedata,
   output logic [1:0]   m_memwrite,
   output logic         m_dword,
   output logic [N-1:0] m_dataadr,
   output logic [N-1:0] m_writedata
);

   localparam int unsigned LMAX = L;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_COLLECT,
      S_CHK,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [55:0] r_shift;     // first seven bytes of the doubleword being assembled
   logic [63:0] r_wbuf;      // completed doubleword waiting for its write cycle
   logic        r_wpend;     // r_wbuf holds a doubleword not yet written
   logic [2:0]  r_idx;       // byte position within the current doubleword
   logic [7:0]  r_count;     // doublewords written so far
   logic [7:0]  r_total;     // doublewords announced by the header
   logic        r_last;      // all payload bytes received; further bytes are not payload
   logic        r_err;
   logic        r_done;
   logic        r_busy;
   logic        r_cpu_reset;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]  r_sum;       // mod-256 sum of payload bytes
`endif

   // Load sequencer: state, byte assembly, write pacing and all registered outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the datapath registers are reset too; they are few and it keeps the port deterministic after reset.
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_wbuf      <= '0;
         r_wpend     <= 1'b0;
         r_idx       <= '0;
         r_count     <= '0;
         r_total     <= '0;
         r_last      <= 1'b0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_cpu_reset <= 1'b1;
`ifdef LOADER_CHKSUM_EN
         r_sum       <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Dropping cpu_reset here gives exactly one extra reset cycle after DONE.
               r_cpu_reset <= 1'b0;
               if (ld_start) begin
                  r_state     <= S_HDR;
                  r_busy      <= 1'b1;
                  r_cpu_reset <= 1'b1;
                  r_err       <= 1'b0;
                  r_count     <= '0;
                  r_idx       <= '0;
                  r_last      <= 1'b0;
                  r_wpend     <= 1'b0;
`ifdef LOADER_CHKSUM_EN
                  r_sum       <= '0;
`endif
               end
            end

            S_HDR: begin
               if (ld_valid) begin
                  r_total <= ld_byte;
                  if (ld_byte == 8'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (32'(ld_byte) > LMAX) begin
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_COLLECT;
                  end
               end
            end

            S_COLLECT: begin
               // Write cycle for the doubleword assembled last cycle.
               if (r_wpend) begin
                  r_wpend <= 1'b0;
                  r_count <= r_count + 8'd1;
                  if (r_count + 8'd1 == r_total) begin
`ifdef LOADER_CHKSUM_EN
                     if (ld_valid && r_last) begin
                        // Checksum byte arrived back-to-back, during the final write.
                        if (r_sum + ld_byte != 8'd0) r_err <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_CHK;
                     end
`else
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
`endif
                  end
               end
               // Payload byte: shift in MSB-first; the 8th byte completes the doubleword.
               if (ld_valid && !r_last) begin
                  r_shift <= {r_shift[47:0], ld_byte};
                  r_idx   <= r_idx + 3'd1;
`ifdef LOADER_CHKSUM_EN
                  r_sum   <= r_sum + ld_byte;
`endif
                  if (r_idx == 3'd7) begin
                     r_wbuf  <= {r_shift, ld_byte};
                     r_wpend <= 1'b1;
                     if (r_count + {7'd0, r_wpend} + 8'd1 == r_total) r_last <= 1'b1;
                  end
               end
            end

`ifdef LOADER_CHKSUM_EN
            S_CHK: begin
               if (ld_valid) begin
                  if (r_sum + ld_byte != 8'd0) r_err <= 1'b1;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
`endif

            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Port mux: the CPU owns the memory port in IDLE, the loader in every other state.
   // NOTE: every output gets a default first so this block can never infer a latch.
   always_comb begin
      m_memwrite  = cpu_memwrite;
      m_dword     = cpu_dword;
      m_dataadr   = cpu_dataadr;
      m_writedata = cpu_writedata;
      if (r_state != S_IDLE) begin
         m_memwrite  = r_wpend ? 2'd3 : 2'd0;
         m_dword     = r_wpend;
         m_dataadr   = N'({r_count, 3'b000});
         m_writedata = N'(r_wbuf);
      end
   end

   assign ld_busy   = r_busy;
   assign ld_done   = r_done;
   assign ld_err    = r_err;
   assign ld_count  = r_count;
   assign cpu_reset = r_cpu_reset;

endmodule

// File: tb/tb_mem_load_arb.sv
// Directed bench for mem_load_arb: pass-through vector table plus hand-written
// load sequences (single word, three words, header errors, reset mid-load).
module tb_mem_load_arb;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         ld_start, ld_valid;
   logic [7:0]   ld_byte;
   logic         ld_busy, ld_done, ld_err, cpu_reset;
   logic [7:0]   ld_count;
   logic [1:0]   cpu_memwrite, m_memwrite;
   logic         cpu_dword, m_dword;
   logic [N-1:0] cpu_dataadr, cpu_writedata, m_dataadr, m_writedata;

   mem_load_arb #(.N(N), .L(128)) dut (
      .clk(clk), .reset(reset),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
      .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .ld_count(ld_count),
      .cpu_reset(cpu_reset),
      .cpu_memwrite(cpu_memwrite), .cpu_dword(cpu_dword),
      .cpu_dataadr(cpu_dataadr), .cpu_writedata(cpu_writedata),
      .m_memwrite(m_memwrite), .m_dword(m_dword),
      .m_dataadr(m_dataadr), .m_writedata(m_writedata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write/cpu_reset monitor, sampled on the falling edge.
   logic [63:0] wr_adr[$];
   logic [63:0] wr_dat[$];
   int          viol = 0;
   always @(negedge clk) begin
      if (m_memwrite == 2'd3) begin
         wr_adr.push_back(m_dataadr);
         wr_dat.push_back(m_writedata);
      end
      if (ld_busy && !cpu_reset) viol++;
   end

   // Driving tasks start and end just after a rising edge.
   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      sync();
      ld_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_byte  = b;
      sync();
      ld_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ld_done && cyc < 60);
      check("ld_done_seen", 64'(ld_done), 64'd1);
   endtask

   // From the DONE cycle: one more cpu_reset cycle in IDLE, then release.
   task automatic post_done(input string tag);
      @(negedge clk);
      check({tag, "_busy_after"}, 64'(ld_busy), 64'd0);
      check({tag, "_done_1cyc"}, 64'(ld_done), 64'd0);
      check({tag, "_cpurst_hold"}, 64'(cpu_reset), 64'd1);
      @(negedge clk);
      check({tag, "_cpurst_rel"}, 64'(cpu_reset), 64'd0);
      sync();
   endtask

   // Full load: header, nwords*8 bytes base, base+1, ... back-to-back (+checksum).
   task automatic run_load(input string tag, input logic [7:0] hdr, input int nwords,
                           input logic [7:0] base, input logic exp_err);
      logic [63:0] w;
      int          cyc;
`ifdef LOADER_CHKSUM_EN
      logic [7:0]  sum = 8'd0;
`endif
      wr_adr.delete();
      wr_dat.delete();
      viol = 0;
      start_load();
      check({tag, "_busy"}, 64'(ld_busy), 64'd1);
      check({tag, "_err_clr"}, 64'(ld_err), 64'd0);
      send_byte(hdr);
      for (int i = 0; i < nwords * 8; i++) begin
`ifdef LOADER_CHKSUM_EN
         sum = sum + (base + 8'(i));
`endif
         send_byte(base + 8'(i));
      end
`ifdef LOADER_CHKSUM_EN
      if (nwords > 0) send_byte(8'd0 - sum);
`endif
      wait_done(cyc);
      check({tag, "_err"}, 64'(ld_err), 64'(exp_err));
      check({tag, "_count"}, 64'(ld_count), 64'(nwords));
      post_done(tag);
      check({tag, "_nwrites"}, 64'(wr_adr.size()), 64'(nwords));
      for (int wi = 0; wi < nwords && wi < wr_adr.size(); wi++) begin
         w = '0;
         for (int k = 0; k < 8; k++) w = {w[55:0], base + 8'(8 * wi + k)};
         check({tag, "_adr"}, wr_adr[wi], 64'(8 * wi));
         check({tag, "_dat"}, wr_dat[wi], w);
      end
      check({tag, "_cpurst_in_load"}, 64'(viol), 64'd0);
   endtask

   typedef struct {
      logic [1:0]  mw;
      logic        dw;
      logic [63:0] adr;
      logic [63:0] wd;
      logic        start;
      logic [1:0]  e_mw;
      logic        e_dw;
      logic [63:0] e_adr;
      logic [63:0] e_wd;
   } vec_t;

   vec_t vecs[5];
   int   cyc;

   initial begin
      // Idle pass-through vectors; the last one coincides with ld_start.
      vecs[0] = '{2'd2, 1'b0, 64'h13,  64'hAB,               1'b0, 2'd2, 1'b0, 64'h13,  64'hAB};
      vecs[1] = '{2'd1, 1'b0, 64'h100, 64'hDEADBEEF,         1'b0, 2'd1, 1'b0, 64'h100, 64'hDEADBEEF};
      vecs[2] = '{2'd3, 1'b1, 64'h18,  64'h1122334455667788, 1'b0, 2'd3, 1'b1, 64'h18,  64'h1122334455667788};
      vecs[3] = '{2'd0, 1'b1, 64'h40,  64'h0,                1'b0, 2'd0, 1'b1, 64'h40,  64'h0};
      vecs[4] = '{2'd2, 1'b0, 64'h13,  64'hAB,               1'b1, 2'd2, 1'b0, 64'h13,  64'hAB};

      reset = 1'b1;
      ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0;
      cpu_memwrite = 2'd0; cpu_dword = 1'b0; cpu_dataadr = '0; cpu_writedata = '0;

      // Reset state.
      @(negedge clk);
      check("rst_busy", 64'(ld_busy), 64'd0);
      check("rst_done", 64'(ld_done), 64'd0);
      check("rst_err", 64'(ld_err), 64'd0);
      check("rst_count", 64'(ld_count), 64'd0);
      check("rst_cpurst", 64'(cpu_reset), 64'd1);
      #2 reset = 1'b0;
      #1 check("rst_cpurst_until_edge", 64'(cpu_reset), 64'd1);
      sync();
      check("rst_cpurst_released", 64'(cpu_reset), 64'd0);

      // Pass-through table.
      foreach (vecs[i]) begin
         cpu_memwrite  = vecs[i].mw;
         cpu_dword     = vecs[i].dw;
         cpu_dataadr   = vecs[i].adr;
         cpu_writedata = vecs[i].wd;
         ld_start      = vecs[i].start;
         @(negedge clk);
         check($sformatf("pt%0d_mw", i), 64'(m_memwrite), 64'(vecs[i].e_mw));
         check($sformatf("pt%0d_dw", i), 64'(m_dword), 64'(vecs[i].e_dw));
         check($sformatf("pt%0d_adr", i), m_dataadr, vecs[i].e_adr);
         check($sformatf("pt%0d_wd", i), m_writedata, vecs[i].e_wd);
         sync();
         ld_start = 1'b0;
      end
      // Loader owns the port now: CPU write request is ignored.
      @(negedge clk);
      check("takeover_mw", 64'(m_memwrite), 64'd0);
      check("takeover_busy", 64'(ld_busy), 64'd1);
      check("takeover_cpurst", 64'(cpu_reset), 64'd1);
      sync();
      cpu_memwrite = 2'd0; cpu_dword = 1'b0; cpu_dataadr = '0; cpu_writedata = '0;
      send_byte(8'h00);
      wait_done(cyc);
      post_done("takeover");

      // Single doubleword with write-latency check.
      wr_adr.delete();
      wr_dat.delete();
      viol = 0;
      start_load();
      send_byte(8'h01);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      @(negedge clk);
      check("w1_mw", 64'(m_memwrite), 64'd3);
      check("w1_adr", m_dataadr, 64'd0);
      check("w1_dat", m_writedata, 64'h0102030405060708);
`ifdef LOADER_CHKSUM_EN
      sync();
      send_byte(8'hDC);
`endif
      wait_done(cyc);
`ifndef LOADER_CHKSUM_EN
      check("w1_done_latency", 64'(cyc), 64'd1);
`endif
      check("w1_err", 64'(ld_err), 64'd0);
      check("w1_count", 64'(ld_count), 64'd1);
      post_done("w1");
      check("w1_nwrites", 64'(wr_adr.size()), 64'd1);
      check("w1_cpurst_in_load", 64'(viol), 64'd0);

      // Three doublewords, then header errors.
      run_load("w3", 8'h03, 3, 8'h10, 1'b0);
      run_load("hdr81", 8'h81, 0, 8'h00, 1'b1);
      check("err_sticky", 64'(ld_err), 64'd1);
      run_load("hdr00", 8'h00, 0, 8'h00, 1'b0);

`ifdef LOADER_CHKSUM_EN
      // Wrong checksum, delivered back-to-back during the write cycle.
      wr_adr.delete();
      wr_dat.delete();
      start_load();
      send_byte(8'h01);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      send_byte(8'h00);
      wait_done(cyc);
      check("badchk_err", 64'(ld_err), 64'd1);
      post_done("badchk");
      check("badchk_nwrites", 64'(wr_adr.size()), 64'd1);
      if (wr_adr.size() > 0) begin
         check("badchk_adr", wr_adr[0], 64'd0);
         check("badchk_dat", wr_dat[0], 64'h0102030405060708);
      end
`endif

      // Reset mid-COLLECT after five payload bytes.
      wr_adr.delete();
      wr_dat.delete();
      start_load();
      send_byte(8'h02);
      for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(ld_busy), 64'd0);
      check("mid_rst_count", 64'(ld_count), 64'd0);
      check("mid_rst_cpurst", 64'(cpu_reset), 64'd1);
      for (int i = 5; i < 8; i++) send_byte(8'h50 + 8'(i));
      #2 reset = 1'b0;
      #1 check("mid_rst_cpurst_hold", 64'(cpu_reset), 64'd1);
      sync();
      check("mid_rst_cpurst_rel", 64'(cpu_reset), 64'd0);
      for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i));
      @(negedge clk);
      check("mid_rst_busy_after", 64'(ld_busy), 64'd0);
      sync();
      check("mid_rst_nwrites", 64'(wr_adr.size()), 64'd0);

      // Clean load after the aborted one.
      run_load("after_rst", 8'h01, 1, 8'hA0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
